div_unit: RTL and testbench
===========================

# div_unit

Sequential RISC-V M-extension divider covering DIV, DIVU, REM and REMU, the function codes 3'b100–3'b111 that the multiplier leaves unimplemented. It sits beside the combinational multiplier in the execute stage and shares its A/B operand buses and MDFunc encoding. Its result feeds the same writeback mux. The block is a radix-2 restoring divider that takes DWIDTH iterations per operation, so the core pipeline must stall on `busy`.

## Interface
- `DWIDTH`, 32, operand and result width.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `A`  in  DWIDTH  dividend (rs1).
- `B`  in  DWIDTH  divisor (rs2).
- `MDFunc`  in  3  function code: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `divEn`  in  1  start request; meaningful only when MDFunc[2]=1.
- `DOut`  out  DWIDTH  result register; reset 0.
- `busy`  out  1  high in CALC and FIX; reset 0.
- `done`  out  1  one-cycle pulse in DONE, when DOut is newly valid; reset 0.

## Operation
- States: IDLE, CALC, FIX, DONE. Reset value is IDLE.
- Start is accepted when the state is IDLE or DONE and `divEn`=1 and MDFunc[2]=1.
  - On accept, latch func, operand signs, and magnitudes |A| and |B| (signed ops only; unsigned ops use raw values).
  - Clear the iteration counter and go to CALC.
- Start with MDFunc[2]=0 is ignored. Start in CALC or FIX is ignored; operands are not re-latched.
- CALC: one restoring step per cycle.
  - Shift {rem,quo} left by 1 and trial-subtract the divisor from rem.
  - If there is no borrow, keep the difference and set the quotient LSB.
  - After DWIDTH steps, go to FIX.
- FIX: apply signs for signed ops.
  - The quotient is negated when the operand signs differ.
  - The remainder takes the sign of the dividend.
  - Select the quotient (DIV/DIVU) or remainder (REM/REMU) into DOut, then go to DONE.
- DONE: `done`=1 for exactly one cycle. Go to IDLE unless a new start is accepted.
- DOut holds its value until the next result is written.
- Special cases skip CALC and FIX; the accept edge goes directly to DONE:
  - B=0: DIV → all-ones, DIVU → all-ones, REM/REMU → A.
  - Signed overflow (A=100…0, B=all-ones, DIV/REM): DIV → A, REM → 0.
- All arithmetic is integer (not the multiplier's Q31 scaling). Intermediate rem is DWIDTH+1 bits to capture the borrow.
- A reset asserted mid-operation aborts immediately: state IDLE, DOut=0, busy=0, done=0, counter cleared.

## Timing
- Start is sampled in cycle 0.
- Normal ops: busy in cycles 1..DWIDTH+1, done in cycle DWIDTH+2 (cycle 34 at DWIDTH=32).
- Special cases: busy never asserts; done in cycle 1.
- Back-to-back: a start in the DONE cycle is accepted, so the next op begins without an IDLE gap.
- `busy` and `done` are registered. The core must treat an accepting cycle plus `busy` as a stall, and sample DOut on `done`.

## Configuration
- `DIV_EARLY_OUT_EN` defined: when the unsigned magnitude |A| < |B| (with B≠0), the accept edge goes directly to DONE.
  - Quotient is 0; remainder is the original A (sign preserved).
  - done arrives in cycle 1.
- Not defined: this case takes the full DWIDTH+2 cycles and yields the same values.

## Structure
- Shared package `muldiv_pkg` holds:
  - MDFunc code localparams (FUNC_MUL … FUNC_REMU), shared with the multiplier;
  - the state enum `div_state_t`;
  - the iteration counter width `$clog2(DWIDTH+1)`.
- Sub-module `div_step`: combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
- The FSM, operand registers, and sign fix-up stay in `div_unit`.

## Test plan
- DIVU A=100, B=7 → DOut=14, done in cycle 34; REMU on the same operands → 2.
- DIV A=-7, B=2 → DOut=-3 (0xFFFFFFFD); REM → -1 (0xFFFFFFFF); REM A=7, B=-2 → 1.
- Divide by zero, B=0:
  - DIVU A=5 → 0xFFFFFFFF, done in cycle 1, busy never high;
  - REM A=-9 → 0xFFFFFFF7.
- Overflow A=0x80000000, B=0xFFFFFFFF: DIV → 0x80000000, REM → 0, done in cycle 1.
- Start pulses while busy:
  - re-pulse `divEn` with new operands in cycles 5 and 20; the result still matches the first operands, done in cycle 34;
  - `reset` in cycle 10 → DOut=0, busy=0 in cycle 11, and no done pulse follows.
- DIVU A=3, B=10 → DOut=0; done in cycle 1 with `DIV_EARLY_OUT_EN`, cycle 34 without.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Definitions shared by the multiplier and divider: MDFunc codes, divider FSM states
// and the iteration counter width helper.
package muldiv_pkg;

  localparam logic [2:0] FUNC_MUL    = 3'b000;
  localparam logic [2:0] FUNC_MULH   = 3'b001;
  localparam logic [2:0] FUNC_MULHSU = 3'b010;
  localparam logic [2:0] FUNC_MULHU  = 3'b011;
  localparam logic [2:0] FUNC_DIV    = 3'b100;
  localparam logic [2:0] FUNC_DIVU   = 3'b101;
  localparam logic [2:0] FUNC_REM    = 3'b110;
  localparam logic [2:0] FUNC_REMU   = 3'b111;

  typedef logic [1:0] div_state_t;

  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_CALC = 2'd1;
  localparam div_state_t DIV_FIX  = 2'd2;
  localparam div_state_t DIV_DONE = 2'd3;

  function automatic int unsigned div_cnt_width(input int unsigned dwidth);
    return $clog2(dwidth + 1);
  endfunction

  localparam int unsigned DIV_CNT_W = div_cnt_width(32);

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left and trial-subtract.
module div_step
  import muldiv_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] rem_i,
  input  logic [DWIDTH-1:0] quo_i,
  input  logic [DWIDTH-1:0] divisor_i,
  output logic [DWIDTH-1:0] rem_o,
  output logic [DWIDTH-1:0] quo_o
);

  logic [DWIDTH:0]   shifted;
  logic [DWIDTH-1:0] diff;
  logic              no_borrow;

  always_comb begin
    shifted   = {rem_i, quo_i[DWIDTH-1]};
    no_borrow = (shifted >= {1'b0, divisor_i});
    // On success the true difference is below the divisor, so modular DWIDTH bits are exact.
    diff      = shifted[DWIDTH-1:0] - divisor_i;
    if (no_borrow) begin
      rem_o = diff;
      quo_o = {quo_i[DWIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[DWIDTH-1:0];
      quo_o = {quo_i[DWIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Sequential radix-2 restoring divider for DIV/DIVU/REM/REMU.
// Optional DIV_EARLY_OUT_EN: finish on the accept edge when |A| < |B|.
module div_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DWIDTH-1:0] A,
  input  logic [DWIDTH-1:0] B,
  input  logic [2:0]        MDFunc,
  input  logic              divEn,
  output logic [DWIDTH-1:0] DOut,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CntW = div_cnt_width(DWIDTH);

  div_state_t        state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DWIDTH-1:0] rem_q, rem_d;
  logic [DWIDTH-1:0] quo_q, quo_d;
  logic [DWIDTH-1:0] dvs_q, dvs_d;
  logic [DWIDTH-1:0] dout_q, dout_d;
  logic [1:0]        func_q, func_d;
  logic              sa_q, sa_d;
  logic              sb_q, sb_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              signed_op, a_neg, b_neg, start, is_ovf;
  logic [DWIDTH-1:0] mag_a, mag_b;
  logic [DWIDTH-1:0] step_rem, step_quo;
  logic [DWIDTH-1:0] q_fix, r_fix, fix_res;

  div_step #(
    .DWIDTH(DWIDTH)
  ) u_step (
    .rem_i    (rem_q),
    .quo_i    (quo_q),
    .divisor_i(dvs_q),
    .rem_o    (step_rem),
    .quo_o    (step_quo)
  );

  always_comb begin
    signed_op = ~MDFunc[0];
    a_neg     = signed_op & A[DWIDTH-1];
    b_neg     = signed_op & B[DWIDTH-1];
    mag_a     = a_neg ? (~A + 1'b1) : A;
    mag_b     = b_neg ? (~B + 1'b1) : B;
    start     = divEn & MDFunc[2] & ((state_q == DIV_IDLE) | (state_q == DIV_DONE));
    is_ovf    = signed_op & (A == {1'b1, {(DWIDTH-1){1'b0}}}) & (&B);
  end

  // Sign fix-up: quotient negated on differing signs, remainder follows the dividend.
  always_comb begin
    q_fix   = (~func_q[0] & (sa_q ^ sb_q)) ? (~quo_q + 1'b1) : quo_q;
    r_fix   = (~func_q[0] & sa_q) ? (~rem_q + 1'b1) : rem_q;
    fix_res = func_q[1] ? r_fix : q_fix;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dout_d  = dout_q;
    func_d  = func_q;
    sa_d    = sa_q;
    sb_d    = sb_q;

    case (state_q)
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == CntW'(DWIDTH - 1)) begin
          state_d = DIV_FIX;
        end
      end
      DIV_FIX: begin
        dout_d  = fix_res;
        state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = state_q;
    endcase

    if (start) begin
      func_d  = MDFunc[1:0];
      sa_d    = a_neg;
      sb_d    = b_neg;
      cnt_d   = '0;
      rem_d   = '0;
      quo_d   = mag_a;
      dvs_d   = mag_b;
      state_d = DIV_CALC;
      if (B == '0) begin
        dout_d  = MDFunc[1] ? A : '1;
        state_d = DIV_DONE;
      end else if (is_ovf) begin
        dout_d  = MDFunc[1] ? '0 : A;
        state_d = DIV_DONE;
      end
`ifdef DIV_EARLY_OUT_EN
      else if (mag_a < mag_b) begin
        dout_d  = MDFunc[1] ? A : '0;
        state_d = DIV_DONE;
      end
`endif
    end

    busy_d = (state_d == DIV_CALC) | (state_d == DIV_FIX);
    done_d = (state_d == DIV_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dout_q  <= '0;
      func_q  <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dout_q  <= dout_d;
      func_q  <= func_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign DOut = dout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus start-while-busy, back-to-back and reset cases.
module tb_div_unit;
  import muldiv_pkg::*;

  localparam int unsigned DWIDTH = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int EC = 1;
`else
  localparam int EC = 34;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [DWIDTH-1:0] A = '0;
  logic [DWIDTH-1:0] B = '0;
  logic [2:0]        MDFunc = 3'b000;
  logic              divEn = 1'b0;
  logic [DWIDTH-1:0] DOut;
  logic              busy;
  logic              done;

  int tests = 0;
  int fails = 0;

  div_unit #(
    .DWIDTH(DWIDTH)
  ) dut (
    .clock (clock),
    .reset (reset),
    .A     (A),
    .B     (B),
    .MDFunc(MDFunc),
    .divEn (divEn),
    .DOut  (DOut),
    .busy  (busy),
    .done  (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a negedge; the start is sampled by the next posedge (cycle 0 -> 1).
  // Cycles p1/p2 re-pulse divEn with unrelated operands.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int p1, input int p2,
                        output logic [31:0] res, output int dcyc, output int bcnt);
    res  = 'x;
    dcyc = -1;
    bcnt = 0;
    MDFunc = f;
    A      = a;
    B      = b;
    divEn  = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clock);
      #1;
      if (c == p1 || c == p2) begin
        divEn  = 1'b1;
        MDFunc = FUNC_DIV;
        A      = 32'd1000;
        B      = 32'd3;
      end else begin
        divEn = 1'b0;
      end
      @(negedge clock);
      if (busy) bcnt++;
      if (done) begin
        dcyc = c;
        res  = DOut;
        break;
      end
    end
    divEn = 1'b0;
  endtask

  logic [31:0] res;
  int          dcyc, bcnt, ndone;

  initial begin
    vecs[0]  = '{"divu_100_7",   FUNC_DIVU, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{"remu_100_7",   FUNC_REMU, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{"div_m7_2",     FUNC_DIV,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  34};
    vecs[3]  = '{"rem_m7_2",     FUNC_REM,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  34};
    vecs[4]  = '{"rem_7_m2",     FUNC_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34};
    vecs[5]  = '{"div_m100_7",   FUNC_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  34};
    vecs[6]  = '{"remu_max_16",  FUNC_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          34};
    vecs[7]  = '{"divu_5_0",     FUNC_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[8]  = '{"rem_m9_0",     FUNC_REM,  32'hFFFF_FFF7,  32'd0,          32'hFFFF_FFF7,  1};
    vecs[9]  = '{"div_5_0",      FUNC_DIV,  32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vecs[10] = '{"div_ovf",      FUNC_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vecs[11] = '{"rem_ovf",      FUNC_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          1};
    vecs[12] = '{"divu_3_10",    FUNC_DIVU, 32'd3,          32'd10,         32'd0,          EC};
    vecs[13] = '{"rem_m3_10",    FUNC_REM,  32'hFFFF_FFFD,  32'd10,         32'hFFFF_FFFD,  EC};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("reset_dout", DOut, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 0, 0, res, dcyc, bcnt);
      check({vecs[i].name, "_dout"}, res, vecs[i].exp);
      check({vecs[i].name, "_cyc"}, dcyc, vecs[i].cyc);
      check({vecs[i].name, "_busycnt"}, bcnt, (vecs[i].cyc == 34) ? 33 : 0);
      @(negedge clock);
      check({vecs[i].name, "_done_once"}, {31'd0, done}, 32'd0);
    end

    // Starts in cycles 5 and 20 land in CALC and must not disturb the operation.
    run_op(FUNC_DIVU, 32'd100, 32'd7, 5, 20, res, dcyc, bcnt);
    check("repulse_dout", res, 32'd14);
    check("repulse_cyc", dcyc, 34);
    @(negedge clock);

    // Back-to-back: second start issued in the DONE cycle of the first.
    run_op(FUNC_DIVU, 32'd1000, 32'd3, 0, 0, res, dcyc, bcnt);
    check("b2b_first_dout", res, 32'd333);
    run_op(FUNC_REMU, 32'd1000, 32'd3, 0, 0, res, dcyc, bcnt);
    check("b2b_second_dout", res, 32'd1);
    check("b2b_second_cyc", dcyc, 34);
    check("b2b_second_busycnt", bcnt, 33);
    @(negedge clock);

    // Reset in cycle 10 of a running divide.
    check("pre_reset_dout", DOut, 32'd1);
    MDFunc = FUNC_DIVU;
    A      = 32'd100;
    B      = 32'd7;
    divEn  = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock);
      #1;
      divEn = 1'b0;
      if (c == 10) reset = 1'b1;
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("midreset_dout", DOut, 32'd0);
    check("midreset_busy", {31'd0, busy}, 32'd0);
    check("midreset_done", {31'd0, done}, 32'd0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (done || busy) ndone++;
    end
    check("midreset_no_activity", ndone, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
